aes_block_streamer: RTL and testbench

//  Parametrised memory-to-memory block-cipher streamer. Reads NUM_BLOCKS blocks (BLOCK_W bits each) from
//  SRC_BASE as DATA_W-bit words, hands each block to an external cipher core (ld/done), writes the result
//  to DST_BASE. Sits between the SDRAM master port and aes_cipher_top; replaces fixed 8x16-bit sequencing.

---
 rtl/aes_block_streamer.sv | 238 +++++++++++++++++++++++
 tb/tb_aes_block_streamer.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_block_streamer.sv
// Memory-to-memory block streamer: reads NUM_BLOCKS blocks, runs each through an external cipher core
// and writes the results back. Define AES_CBC_EN for CBC chaining; the default build is ECB.
module aes_block_streamer #(
  parameter int ADDR_W  = 25,
  parameter int DATA_W  = 16,
  parameter int BLOCK_W = 128,
  parameter int RD_LAT  = 2,
  parameter int TIMEOUT = 255
) (
  input  logic               iCLK,
  input  logic               iRST_n,
  input  logic               iSTART,
  input  logic [ADDR_W-1:0]  iSRC_BASE,
  input  logic [ADDR_W-1:0]  iDST_BASE,
  input  logic [15:0]        iNUM_BLOCKS,
  input  logic [BLOCK_W-1:0] iIV,
  output logic [ADDR_W-1:0]  oADDR,
  output logic               oREAD,
  output logic               oWRITE,
  output logic [DATA_W-1:0]  oWRITEDATA,
  input  logic [DATA_W-1:0]  iREADDATA,
  input  logic               iWAITREQ,
  output logic               oC_LD,
  output logic [BLOCK_W-1:0] oC_TEXT_IN,
  input  logic               iC_DONE,
  input  logic [BLOCK_W-1:0] iC_TEXT_OUT,
  output logic               oBUSY,
  output logic               oDONE,
  output logic               oERR,
  output logic [15:0]        oBLK_CNT,
  output logic [3:0]         oSTATE
);

  localparam int WORDS = BLOCK_W / DATA_W;
  localparam int W_W   = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int LAT_W = $clog2(RD_LAT + 1);
  localparam int TO_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [W_W-1:0] LAST_W = W_W'(WORDS - 1);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_RD_REQ  = 4'd1,
    S_RD_WAIT = 4'd2,
    S_LOAD    = 4'd3,
    S_CWAIT   = 4'd4,
    S_WR_REQ  = 4'd5,
    S_WR_GAP  = 4'd6,
    S_NEXT    = 4'd7,
    S_FIN     = 4'd8,
    S_ERR     = 4'd9
  } state_t;

  state_t             r_state;
  logic               r_start_prev;
  logic [ADDR_W-1:0]  r_src;
  logic [ADDR_W-1:0]  r_dst;
  logic [15:0]        r_num;
  logic [W_W-1:0]     r_w;
  logic [LAT_W-1:0]   r_lat;
  logic [TO_W-1:0]    r_to;
  logic [BLOCK_W-1:0] r_blk;
  logic [BLOCK_W-1:0] r_res;

  logic               w_start;
  logic [W_W-1:0]     w_w_nxt;
  logic [15:0]        w_cnt_nxt;
  logic [BLOCK_W-1:0] w_blk_fill;
  logic [BLOCK_W-1:0] w_text_next;

  assign w_start   = iSTART & ~r_start_prev;
  assign w_w_nxt   = r_w + 1'b1;
  assign w_cnt_nxt = oBLK_CNT + 16'd1;
  assign oSTATE    = r_state;

  // Block being assembled, with the word arriving this cycle already in its slot (word 0 = LSBs).
  always_comb begin
    w_blk_fill = r_blk;
    w_blk_fill[r_w*DATA_W +: DATA_W] = iREADDATA;
  end

`ifdef AES_CBC_EN
  logic [BLOCK_W-1:0] r_chain;

  assign w_text_next = w_blk_fill ^ r_chain;

  always_ff @(posedge iCLK) begin
    if (!iRST_n) begin
      r_chain <= '0;
    end else if (r_state == S_IDLE && w_start) begin
      r_chain <= iIV;
    end else if (r_state == S_CWAIT && iC_DONE) begin
      r_chain <= iC_TEXT_OUT;
    end
  end
`else
  logic w_unused_iv;
  assign w_unused_iv = ^iIV;
  assign w_text_next = w_blk_fill;
`endif

  // Handshakes: oREAD/oWRITE are held with stable oADDR/oWRITEDATA until a cycle with iWAITREQ=0,
  // which is the transfer; the cipher gets one oC_LD pulse and answers with one iC_DONE pulse.
  always_ff @(posedge iCLK) begin
    if (!iRST_n) begin
      r_state      <= S_IDLE;
      r_start_prev <= 1'b0;
      r_src        <= '0;
      r_dst        <= '0;
      r_num        <= '0;
      r_w          <= '0;
      r_lat        <= '0;
      r_to         <= '0;
      r_blk        <= '0;
      r_res        <= '0;
      oADDR        <= '0;
      oREAD        <= 1'b0;
      oWRITE       <= 1'b0;
      oWRITEDATA   <= '0;
      oC_LD        <= 1'b0;
      oC_TEXT_IN   <= '0;
      oBUSY        <= 1'b0;
      oDONE        <= 1'b0;
      oERR         <= 1'b0;
      oBLK_CNT     <= '0;
    end else begin
      r_start_prev <= iSTART;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            oDONE    <= 1'b0;
            oERR     <= 1'b0;
            oBLK_CNT <= '0;
            oBUSY    <= 1'b1;
            r_src    <= iSRC_BASE;
            r_dst    <= iDST_BASE;
            r_num    <= iNUM_BLOCKS;
            r_w      <= '0;
            if (iNUM_BLOCKS == 16'd0) begin
              r_state <= S_FIN;
            end else begin
              oREAD   <= 1'b1;
              oADDR   <= iSRC_BASE;
              r_state <= S_RD_REQ;
            end
          end
        end
        S_RD_REQ: begin
          if (!iWAITREQ) begin
            oREAD   <= 1'b0;
            r_src   <= r_src + ADDR_W'(1);
            r_lat   <= LAT_W'(1);
            r_state <= S_RD_WAIT;
          end
        end
        S_RD_WAIT: begin
          if (r_lat == LAT_W'(RD_LAT)) begin
            r_blk <= w_blk_fill;
            if (r_w == LAST_W) begin
              r_w        <= '0;
              oC_LD      <= 1'b1;
              oC_TEXT_IN <= w_text_next;
              r_state    <= S_LOAD;
            end else begin
              r_w     <= w_w_nxt;
              oREAD   <= 1'b1;
              oADDR   <= r_src;
              r_state <= S_RD_REQ;
            end
          end else begin
            r_lat <= r_lat + 1'b1;
          end
        end
        S_LOAD: begin
          oC_LD   <= 1'b0;
          r_to    <= '0;
          r_state <= S_CWAIT;
        end
        S_CWAIT: begin
          if (iC_DONE) begin
            r_res      <= iC_TEXT_OUT;
            oWRITE     <= 1'b1;
            oADDR      <= r_dst;
            oWRITEDATA <= iC_TEXT_OUT[DATA_W-1:0];
            r_state    <= S_WR_REQ;
          end else if (r_to == TO_W'(TIMEOUT)) begin
            r_state <= S_ERR;
          end else begin
            r_to <= r_to + 1'b1;
          end
        end
        S_WR_REQ: begin
          if (!iWAITREQ) begin
            oWRITE  <= 1'b0;
            r_dst   <= r_dst + ADDR_W'(1);
            r_state <= S_WR_GAP;
          end
        end
        S_WR_GAP: begin
          if (r_w == LAST_W) begin
            r_w     <= '0;
            r_state <= S_NEXT;
          end else begin
            r_w        <= w_w_nxt;
            oWRITE     <= 1'b1;
            oADDR      <= r_dst;
            oWRITEDATA <= r_res[w_w_nxt*DATA_W +: DATA_W];
            r_state    <= S_WR_REQ;
          end
        end
        S_NEXT: begin
          oBLK_CNT <= w_cnt_nxt;
          if (w_cnt_nxt == r_num) begin
            r_state <= S_FIN;
          end else begin
            oREAD   <= 1'b1;
            oADDR   <= r_src;
            r_state <= S_RD_REQ;
          end
        end
        S_FIN: begin
          oDONE   <= 1'b1;
          oBUSY   <= 1'b0;
          r_state <= S_IDLE;
        end
        S_ERR: begin
          oERR    <= 1'b1;
          oBUSY   <= 1'b0;
          oREAD   <= 1'b0;
          oWRITE  <= 1'b0;
          oC_LD   <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_block_streamer.sv
// Directed bench for aes_block_streamer: memory model with optional stalls, cipher model, word scoreboard.
module tb_aes_block_streamer;

  localparam int ADDR_W  = 25;
  localparam int DATA_W  = 16;
  localparam int BLOCK_W = 128;
  localparam int RD_LAT  = 2;
  localparam int TIMEOUT = 255;
  localparam int C_LAT   = 4;
`ifdef AES_CBC_EN
  localparam bit CBC = 1'b1;
`else
  localparam bit CBC = 1'b0;
`endif

  logic               iCLK = 1'b0;
  logic               iRST_n;
  logic               iSTART;
  logic [ADDR_W-1:0]  iSRC_BASE;
  logic [ADDR_W-1:0]  iDST_BASE;
  logic [15:0]        iNUM_BLOCKS;
  logic [BLOCK_W-1:0] iIV;
  logic [ADDR_W-1:0]  oADDR;
  logic               oREAD;
  logic               oWRITE;
  logic [DATA_W-1:0]  oWRITEDATA;
  logic [DATA_W-1:0]  iREADDATA;
  logic               iWAITREQ;
  logic               oC_LD;
  logic [BLOCK_W-1:0] oC_TEXT_IN;
  logic               iC_DONE;
  logic [BLOCK_W-1:0] iC_TEXT_OUT;
  logic               oBUSY;
  logic               oDONE;
  logic               oERR;
  logic [15:0]        oBLK_CNT;
  logic [3:0]         oSTATE;

  aes_block_streamer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BLOCK_W(BLOCK_W), .RD_LAT(RD_LAT), .TIMEOUT(TIMEOUT)
  ) dut (
    .iCLK(iCLK), .iRST_n(iRST_n), .iSTART(iSTART),
    .iSRC_BASE(iSRC_BASE), .iDST_BASE(iDST_BASE), .iNUM_BLOCKS(iNUM_BLOCKS), .iIV(iIV),
    .oADDR(oADDR), .oREAD(oREAD), .oWRITE(oWRITE), .oWRITEDATA(oWRITEDATA),
    .iREADDATA(iREADDATA), .iWAITREQ(iWAITREQ),
    .oC_LD(oC_LD), .oC_TEXT_IN(oC_TEXT_IN), .iC_DONE(iC_DONE), .iC_TEXT_OUT(iC_TEXT_OUT),
    .oBUSY(oBUSY), .oDONE(oDONE), .oERR(oERR), .oBLK_CNT(oBLK_CNT), .oSTATE(oSTATE)
  );

  // ---------------- clock ----------------
  always #5 iCLK = ~iCLK;

  // ---------------- bench state ----------------
  int n_pass = 0;
  int n_checks = 0;
  logic [DATA_W-1:0] exp_q[$];

  // written by the stimulus process only
  logic [DATA_W-1:0] src_mem [0:4095];
  bit stall_en = 1'b0;
  bit c_en = 1'b1;
  bit c_ident = 1'b0;

  // written by the model process only
  logic [DATA_W-1:0] dst_mem [0:4095];
  logic              h_v [0:RD_LAT];
  logic [ADDR_W-1:0] h_a [0:RD_LAT];
  int c_cnt = 0;
  logic [BLOCK_W-1:0] c_text = '0;
  logic [BLOCK_W-1:0] last_ld_text = '0;
  bit in_acc = 1'b0;
  int stall_left = 0;
  int acc_idx = 0;
  logic [ADDR_W-1:0] h_addr = '0;
  logic h_rd = 1'b0;
  logic [DATA_W-1:0] h_wd = '0;
  int hold_err = 0;
  int both_cnt = 0;
  int stall_cnt = 0;
  int rd_strobe_cnt = 0;
  int wr_strobe_cnt = 0;

  // ---------------- memory + cipher model (driven on the falling edge) ----------------
  always @(negedge iCLK) begin
    iC_DONE = 1'b0;
    if (c_cnt > 0) begin
      c_cnt = c_cnt - 1;
      if (c_cnt == 0) begin
        iC_DONE = 1'b1;
        iC_TEXT_OUT = c_ident ? c_text : ~c_text;
      end
    end
    if (oC_LD) begin
      c_text = oC_TEXT_IN;
      last_ld_text = oC_TEXT_IN;
      if (c_en) c_cnt = C_LAT;
    end

    for (int k = RD_LAT; k > 0; k--) begin
      h_v[k] = h_v[k-1];
      h_a[k] = h_a[k-1];
    end
    h_v[0] = 1'b0;

    if (oREAD && oWRITE) both_cnt = both_cnt + 1;
    if (oREAD || oWRITE) begin
      if (oREAD) rd_strobe_cnt = rd_strobe_cnt + 1;
      if (oWRITE) wr_strobe_cnt = wr_strobe_cnt + 1;
      if (!in_acc) begin
        in_acc = 1'b1;
        stall_left = (stall_en && acc_idx[0]) ? 3 : 0;
        h_addr = oADDR;
        h_rd = oREAD;
        h_wd = oWRITEDATA;
      end else if (oADDR != h_addr || oREAD != h_rd || (!h_rd && oWRITEDATA != h_wd)) begin
        hold_err = hold_err + 1;
      end
      if (stall_left > 0) begin
        iWAITREQ = 1'b1;
        stall_left = stall_left - 1;
        stall_cnt = stall_cnt + 1;
      end else begin
        iWAITREQ = 1'b0;
        in_acc = 1'b0;
        acc_idx = acc_idx + 1;
        if (oREAD) begin
          h_v[0] = 1'b1;
          h_a[0] = oADDR;
        end else begin
          dst_mem[oADDR[11:0]] = oWRITEDATA;
        end
      end
    end else begin
      iWAITREQ = 1'b0;
    end
    iREADDATA = h_v[RD_LAT] ? src_mem[h_a[RD_LAT][11:0]] : 16'hDEAD;
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [BLOCK_W-1:0] got, input logic [BLOCK_W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Expected output words of a job: cipher model applied per block, chained when CBC is built in.
  task automatic build_exp(input int src, input int nblk, input bit ident, input logic [BLOCK_W-1:0] iv);
    logic [BLOCK_W-1:0] chain, x, y;
    chain = iv;
    for (int b = 0; b < nblk; b++) begin
      for (int k = 0; k < 8; k++) x[k*16 +: 16] = src_mem[src + b*8 + k];
      if (CBC) x = x ^ chain;
      y = ident ? x : ~x;
      chain = y;
      for (int k = 0; k < 8; k++) exp_q.push_back(y[k*16 +: 16]);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic start_job(input logic [ADDR_W-1:0] src, input logic [ADDR_W-1:0] dst,
                           input logic [15:0] num, input logic [BLOCK_W-1:0] iv);
    @(negedge iCLK);
    iSRC_BASE = src;
    iDST_BASE = dst;
    iNUM_BLOCKS = num;
    iIV = iv;
    iSTART = 1'b1;
    @(negedge iCLK);
    iSTART = 1'b0;
  endtask

  task automatic wait_end(input string tag, input int budget, output int n);
    n = 0;
    while (!(oDONE || oERR) && n < budget) begin
      @(negedge iCLK);
      n++;
    end
    check(tag, oDONE | oERR, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int snap_a, snap_b, snap_c;
    iRST_n = 1'b0;
    iSTART = 1'b0;
    iSRC_BASE = '0;
    iDST_BASE = '0;
    iNUM_BLOCKS = '0;
    iIV = '0;
    for (int i = 0; i < 4096; i++) src_mem[i] = 16'h0;
    for (int i = 0; i < 8; i++)  src_mem[12'h100 + i] = 16'(i);
    for (int i = 0; i < 24; i++) src_mem[12'h300 + i] = 16'h1000 + 16'(i);
    for (int i = 0; i < 24; i++) src_mem[12'h500 + i] = 16'h2000 + 16'(i);
    for (int i = 0; i < 16; i++) src_mem[12'h700 + i] = 16'h0700 + 16'(i);

    repeat (3) @(negedge iCLK);
    check("rst_busy", oBUSY, 1'b0);
    check("rst_done", oDONE, 1'b0);
    check("rst_err", oERR, 1'b0);
    check("rst_strobes", {oREAD, oWRITE, oC_LD}, 3'b000);
    check("rst_addr", oADDR, 25'h0);
    check("rst_cnt", oBLK_CNT, 16'h0);
    check("rst_state", oSTATE, 4'd0);
    check("rst_text", oC_TEXT_IN, 128'h0);
    iRST_n = 1'b1;
    @(negedge iCLK);

    // 1: single block, inverting cipher; 24 read + 1 load + 4 cipher + 16 write + 1 next + 1 fin cycles
    start_job(25'h100, 25'h200, 16'd1, '0);
    wait_end("t1_end", 300, n);
    check("t1_latency", n, 47);
    check("t1_done", oDONE, 1'b1);
    check("t1_err", oERR, 1'b0);
    check("t1_busy", oBUSY, 1'b0);
    check("t1_cnt", oBLK_CNT, 16'd1);
    check("t1_text_in", last_ld_text, 128'h0007_0006_0005_0004_0003_0002_0001_0000);
    for (int i = 0; i < 8; i++) check($sformatf("t1_word%0d", i), dst_mem[12'h200 + i], 16'hFFFF - 16'(i));

    // 2: three blocks with a 3-cycle stall on every second access
    snap_a = hold_err;
    snap_b = stall_cnt;
    snap_c = both_cnt;
    stall_en = 1'b1;
    build_exp(12'h300, 3, 1'b0, '0);
    start_job(25'h300, 25'h400, 16'd3, '0);
    wait_end("t2_end", 3000, n);
    stall_en = 1'b0;
    check("t2_done", oDONE, 1'b1);
    check("t2_cnt", oBLK_CNT, 16'd3);
    check("t2_stalled", stall_cnt - snap_b > 0, 1'b1);
    check("t2_hold", hold_err - snap_a, 0);
    check("t2_rd_wr_excl", both_cnt - snap_c, 0);
    for (int i = 0; i < 24; i++) check($sformatf("t2_word%0d", i), dst_mem[12'h400 + i], exp_q.pop_front());

    // 3: empty job finishes without touching memory
    snap_a = rd_strobe_cnt + wr_strobe_cnt;
    start_job(25'h100, 25'h2A0, 16'd0, '0);
    check("t3_done_early", oDONE, 1'b0);
    check("t3_busy_fin", oBUSY, 1'b1);
    @(negedge iCLK);
    check("t3_done", oDONE, 1'b1);
    check("t3_busy", oBUSY, 1'b0);
    check("t3_cnt", oBLK_CNT, 16'd0);
    check("t3_no_strobe", rd_strobe_cnt + wr_strobe_cnt - snap_a, 0);

    // 4: cipher never answers; oERR appears TIMEOUT+3 cycles after the cycle showing oC_LD
    c_en = 1'b0;
    snap_a = wr_strobe_cnt;
    start_job(25'h100, 25'h280, 16'd1, '0);
    n = 0;
    while (!oC_LD && n < 200) begin
      @(negedge iCLK);
      n++;
    end
    check("t4_ld_seen", oC_LD, 1'b1);
    n = 0;
    while (!oERR && n < 600) begin
      @(negedge iCLK);
      n++;
    end
    check("t4_err_lat", n, TIMEOUT + 3);
    check("t4_err", oERR, 1'b1);
    check("t4_done", oDONE, 1'b0);
    check("t4_busy", oBUSY, 1'b0);
    check("t4_no_write", wr_strobe_cnt - snap_a, 0);
    c_en = 1'b1;

    // 5: reset during the writes of the second block, then a clean job
    start_job(25'h500, 25'h580, 16'd3, '0);
    n = 0;
    while (!(oWRITE && oBLK_CNT == 16'd1) && n < 400) begin
      @(negedge iCLK);
      n++;
    end
    check("t5_in_write", oWRITE, 1'b1);
    iRST_n = 1'b0;
    @(negedge iCLK);
    check("t5_rst_strobes", {oREAD, oWRITE, oC_LD}, 3'b000);
    check("t5_rst_status", {oBUSY, oDONE, oERR}, 3'b000);
    check("t5_rst_cnt", oBLK_CNT, 16'd0);
    check("t5_rst_state", oSTATE, 4'd0);
    check("t5_rst_addr", oADDR, 25'h0);
    iRST_n = 1'b1;
    snap_a = rd_strobe_cnt + wr_strobe_cnt;
    repeat (5) @(negedge iCLK);
    check("t5_quiet", rd_strobe_cnt + wr_strobe_cnt - snap_a, 0);
    start_job(25'h100, 25'h600, 16'd1, '0);
    wait_end("t5_end", 300, n);
    check("t5_done", oDONE, 1'b1);
    check("t5_cnt", oBLK_CNT, 16'd1);
    for (int i = 0; i < 8; i++) check($sformatf("t5_word%0d", i), dst_mem[12'h600 + i], 16'hFFFF - 16'(i));

`ifdef AES_CBC_EN
    // 6: CBC with all-ones IV and identity cipher
    c_ident = 1'b1;
    start_job(25'h700, 25'h780, 16'd2, {BLOCK_W{1'b1}});
    wait_end("t6_end", 400, n);
    check("t6_done", oDONE, 1'b1);
    check("t6_cnt", oBLK_CNT, 16'd2);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t6_b0_word%0d", i), dst_mem[12'h780 + i], ~(16'h0700 + 16'(i)));
      check($sformatf("t6_b1_word%0d", i), dst_mem[12'h788 + i],
            (16'h0708 + 16'(i)) ^ ~(16'h0700 + 16'(i)));
    end
    c_ident = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
